// File: rtl/pong_input_pkg.sv
// Shared definitions for the Pong input front-end: channel indices,
// the released pin level and default timing constants (50 MHz clock).
package pong_input_pkg;

   localparam int CH_UP   = 0;
   localparam int CH_DOWN = 1;
   localparam int CH_FIRE = 2;
   localparam int NUM_CH  = 3;

   // Joystick pins idle high; a low level means pressed.
   localparam logic RELEASED = 1'b1;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;     // 10 ms
   localparam int DEF_REPEAT_DELAY    = 25000000;   // 500 ms
   localparam int DEF_REPEAT_PERIOD   = 5000000;    // 100 ms
   localparam int DEF_CNT_W           = 25;

   typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-FF synchronizer, debounce counter and stable register.
// Exports the next-state stable level and a press event (stable about to go
// 1->0) so the parent can register its outputs on the very same edge.
module debounce_channel
   import pong_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_n,
   output logic stable_nxt,
   output logic press_nxt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_d;

   // Next state: synchronizer shift plus the restart-on-bounce debounce count.
   always_comb begin
      sync1_d  = raw_n;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      press_d  = 1'b0;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         press_d  = (sync2_q != RELEASED);
      end else begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // State registers; reset returns to released and drops any partial count.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q  <= RELEASED;
         sync2_q  <= RELEASED;
         stable_q <= RELEASED;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_nxt = stable_d;
   assign press_nxt  = press_d;

endmodule

// File: rtl/joystick_conditioner.sv
// Joystick/button conditioner: debounced active-low levels for the menus and
// one-cycle active-high press strobes for the game logic. Up+down held
// together reads as neutral. Optional auto-repeat of up/down is enabled by
// defining JOYSTICK_AUTOREPEAT_EN.
module joystick_conditioner
   import pong_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_up_n,
   input  logic raw_down_n,
   input  logic raw_fire_n,
   output logic control_up,
   output logic control_down,
   output logic control_fire,
   output logic up_pulse,
   output logic down_pulse,
   output logic fire_pulse
);

   ch_vec_t raw_n_s;
   ch_vec_t stable_d;
   ch_vec_t press_d;
   ch_vec_t control_d, control_q;
   ch_vec_t pulse_d, pulse_q;
   logic    conflict_d;

   // Bad timing parameters are caught when the design is elaborated.
   if ((DEBOUNCE_CYCLES < 1) || (REPEAT_PERIOD < 1) || (REPEAT_DELAY < REPEAT_PERIOD)) begin : g_bad_params
      $error("joystick_conditioner: invalid timing parameters");
   end

   assign raw_n_s[CH_UP]   = raw_up_n;
   assign raw_n_s[CH_DOWN] = raw_down_n;
   assign raw_n_s[CH_FIRE] = raw_fire_n;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clock      (clock),
         .reset      (reset),
         .raw_n      (raw_n_s[ch]),
         .stable_nxt (stable_d[ch]),
         .press_nxt  (press_d[ch])
      );
   end

`ifdef JOYSTICK_AUTOREPEAT_EN
   // Hold counters run DELAY-PERIOD+1 .. DELAY after the first repeat, so
   // every visit to DELAY is one repeat event and the counter never grows.
   localparam int                NUM_DIR     = 2;
   localparam logic [CNT_W-1:0]  HOLD_FIRE   = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [CNT_W-1:0]   hold_q [NUM_DIR];
   logic [CNT_W-1:0]   hold_d [NUM_DIR];
   logic [NUM_DIR-1:0] rep_q, rep_d;
   logic [NUM_DIR-1:0] active_d;
`endif

   // Conflict masking, press strobes and (optionally) auto-repeat events.
   always_comb begin
      conflict_d = (stable_d[CH_UP] != RELEASED) && (stable_d[CH_DOWN] != RELEASED);
      control_d  = stable_d;
      pulse_d    = press_d;
      control_d[CH_UP]   = conflict_d ? RELEASED : stable_d[CH_UP];
      control_d[CH_DOWN] = conflict_d ? RELEASED : stable_d[CH_DOWN];
      pulse_d[CH_UP]     = press_d[CH_UP]   & ~conflict_d;
      pulse_d[CH_DOWN]   = press_d[CH_DOWN] & ~conflict_d;
`ifdef JOYSTICK_AUTOREPEAT_EN
      // Directions share indices 0/1 with CH_UP/CH_DOWN.
      for (int dir = 0; dir < NUM_DIR; dir++) begin
         active_d[dir] = (stable_d[dir] != RELEASED) && !conflict_d;
         if (!active_d[dir] || press_d[dir]) begin
            hold_d[dir] = '0;
         end else if (hold_q[dir] == HOLD_FIRE) begin
            hold_d[dir] = HOLD_RELOAD;
         end else begin
            hold_d[dir] = hold_q[dir] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         rep_d[dir]     = active_d[dir] && (hold_d[dir] == HOLD_FIRE);
         control_d[dir] = control_d[dir] | rep_d[dir];
         pulse_d[dir]   = pulse_d[dir] | (rep_q[dir] & active_d[dir]);
      end
`endif
   end

   // Output registers: levels and strobes update on the acceptance edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         control_q <= {NUM_CH{RELEASED}};
         pulse_q   <= '0;
      end else begin
         control_q <= control_d;
         pulse_q   <= pulse_d;
      end
   end

`ifdef JOYSTICK_AUTOREPEAT_EN
   // Hold counters and the pending-repeat flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int dir = 0; dir < NUM_DIR; dir++) begin
            hold_q[dir] <= '0;
         end
         rep_q <= '0;
      end else begin
         for (int dir = 0; dir < NUM_DIR; dir++) begin
            hold_q[dir] <= hold_d[dir];
         end
         rep_q <= rep_d;
      end
   end
`endif

   assign control_up   = control_q[CH_UP];
   assign control_down = control_q[CH_DOWN];
   assign control_fire = control_q[CH_FIRE];
   assign up_pulse     = pulse_q[CH_UP];
   assign down_pulse   = pulse_q[CH_DOWN];
   assign fire_pulse   = pulse_q[CH_FIRE];

endmodule
